// File: rtl/rpsc_interlock_card_if.sv
// rpsc_interlock_card_if: bundle between the RPSC backplane and the interlock card.
//   master : drives the raw field inputs and ack_clr, observes the card status lines
//   slave  : the interlock card itself
// Signals
//   alarm_in[N_ALARM], an_ps_in, ps_act_in, u_low_in, ack_clr      backplane -> card
//   not_alarm, ground_hold_ok, not_on_perm, not_ps_on, not_ps_ok,
//   not_u_low, first_fault[FF_W], state[3], fault_count[8]          card -> backplane
interface rpsc_interlock_card_if #(
  parameter int unsigned N_ALARM = 7
);
  localparam int unsigned FF_W = $clog2(N_ALARM + 1);

  logic [N_ALARM-1:0] alarm_in;
  logic               an_ps_in;
  logic               ps_act_in;
  logic               u_low_in;
  logic               ack_clr;

  logic               not_alarm;
  logic               ground_hold_ok;
  logic               not_on_perm;
  logic               not_ps_on;
  logic               not_ps_ok;
  logic               not_u_low;
  logic [FF_W-1:0]    first_fault;
  logic [2:0]         state;
  logic [7:0]         fault_count;

  modport master (
    output alarm_in, an_ps_in, ps_act_in, u_low_in, ack_clr,
    input  not_alarm, ground_hold_ok, not_on_perm, not_ps_on, not_ps_ok, not_u_low,
    input  first_fault, state, fault_count
  );

  modport slave (
    input  alarm_in, an_ps_in, ps_act_in, u_low_in, ack_clr,
    output not_alarm, ground_hold_ok, not_on_perm, not_ps_on, not_ps_ok, not_u_low,
    output first_fault, state, fault_count
  );
endinterface

// File: rtl/rpsc_interlock_card.sv
// rpsc_interlock_card: RPSC interlock card. Synchronises and debounces N alarm channels plus the
// anode-PS block, PS-active and U-low inputs, latches alarms, captures the first fault and
// sequences IDLE -> WAIT_ACT -> QUALIFY -> RUN, with FAULT overriding everything.
// Ports
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   bus    : rpsc_interlock_card_if.slave (raw inputs, ack_clr, active-low status lines,
//            first_fault, state, fault_count)
// Build option
//   RPSC_FAULT_COUNT_EN : when defined, fault_count counts FAULT entries (saturating at 255);
//                         otherwise fault_count is tied to zero.
module rpsc_interlock_card #(
  parameter int unsigned        N_ALARM      = 7,
  parameter logic [N_ALARM-1:0] ALARM_MASK   = '0,
  parameter int unsigned        DEB_CYCLES   = 16,
  parameter int unsigned        QUAL_CYCLES  = 1562500,
  parameter bit                 LATCH_ALARMS = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  rpsc_interlock_card_if.slave bus
);
  localparam int unsigned N_IN  = N_ALARM + 3;
  localparam int unsigned FF_W  = $clog2(N_ALARM + 1);
  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int unsigned CNT_W = $clog2(QUAL_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(QUAL_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitAct = 3'd1,
    StQualify = 3'd2,
    StRun     = 3'd3,
    StFault   = 3'd4
  } state_e;

  // Input vector layout: {u_low, ps_act, an_ps, alarm[N_ALARM-1:0]}
  logic [N_IN-1:0]             raw, sync1_q, sync2_q, filt_q, filt_d;
  logic [N_IN-1:0][DEB_W-1:0]  deb_cnt_q, deb_cnt_d;

  logic [N_ALARM-1:0] act, latched_q, latched_d;
  logic               an_ps_f, ps_act_f, u_low_f;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FF_W-1:0]    first_fault_q, first_fault_d, ff_idx;
  logic               fault_entry;

  assign raw = {bus.u_low_in, bus.ps_act_in, bus.an_ps_in, bus.alarm_in};

  // Debounce: flip only after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    filt_d    = filt_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          filt_d[i]    = sync2_q[i];
          deb_cnt_d[i] = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end else begin
        deb_cnt_d[i] = '0;
      end
    end
  end

  assign an_ps_f  = filt_q[N_ALARM];
  assign ps_act_f = filt_q[N_ALARM+1];
  assign u_low_f  = filt_q[N_ALARM+2];
  assign act      = filt_q[N_ALARM-1:0] & ~ALARM_MASK;

  // ack_clr can only clear channels that are no longer active, so a new alarm wins.
  always_comb begin
    if (LATCH_ALARMS) latched_d = bus.ack_clr ? act : (latched_q | act);
    else              latched_d = act;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StQualify) cnt_d = cnt_q + 1'b1;
    if (state_q != StFault && latched_q != '0) begin
      state_d = StFault;
    end else begin
      case (state_q)
        StIdle:    if (!an_ps_f) state_d = StWaitAct;
        StWaitAct: begin
          if (an_ps_f) begin
            state_d = StIdle;
          end else if (ps_act_f) begin
            state_d = StQualify;
            cnt_d   = '0;
          end
        end
        StQualify: begin
          if (an_ps_f) begin
            state_d = StIdle;
          end else if (!ps_act_f) begin
            state_d = StWaitAct;
            cnt_d   = '0;
          end else if (cnt_q == QUAL_LAST) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (an_ps_f)        state_d = StIdle;
          else if (!ps_act_f) state_d = StWaitAct;
        end
        StFault:   if (latched_q == '0) state_d = StIdle;
        default:   state_d = StFault;
      endcase
    end
  end

  // Lowest set channel wins when several alarms latch together.
  always_comb begin
    ff_idx = '0;
    for (int i = int'(N_ALARM) - 1; i >= 0; i--) begin
      if (latched_q[i]) ff_idx = FF_W'(i + 1);
    end
  end

  assign fault_entry = (state_q != StFault) && (state_d == StFault);

  always_comb begin
    first_fault_d = first_fault_q;
    if (fault_entry)                             first_fault_d = ff_idx;
    else if (bus.ack_clr && state_q != StFault) first_fault_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      filt_q        <= '0;
      deb_cnt_q     <= '0;
      latched_q     <= '0;
      state_q       <= StFault;
      cnt_q         <= '0;
      first_fault_q <= '0;
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      filt_q        <= filt_d;
      deb_cnt_q     <= deb_cnt_d;
      latched_q     <= latched_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      first_fault_q <= first_fault_d;
    end
  end

`ifdef RPSC_FAULT_COUNT_EN
  logic [7:0] fault_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_count_q <= '0;
    end else if (fault_entry && fault_count_q != 8'hff) begin
      fault_count_q <= fault_count_q + 8'd1;
    end
  end

  assign bus.fault_count = fault_count_q;
`else
  assign bus.fault_count = 8'd0;
`endif

  assign bus.state          = state_q;
  assign bus.not_alarm      = (state_q != StFault);
  assign bus.ground_hold_ok = (state_q == StWaitAct) || (state_q == StQualify) ||
                              (state_q == StRun);
  assign bus.not_on_perm    = ~bus.ground_hold_ok;
  assign bus.not_ps_on      = ~ps_act_f;
  assign bus.not_ps_ok      = (state_q != StRun);
  assign bus.not_u_low      = ~((state_q == StRun) & u_low_f);
  assign bus.first_fault    = first_fault_q;
endmodule

// File: tb/tb_rpsc_interlock_card.sv
// Bench for rpsc_interlock_card: two cards share the same inputs (one unmasked, one with alarm
// channel 2 masked). A behavioural model tracks both and every output is compared each cycle,
// alongside directed timing checks for the qualification and fault sequences.
module tb_rpsc_interlock_card;
  localparam int unsigned NA   = 7;
  localparam int unsigned DEB  = 4;
  localparam int unsigned QUAL = 100;
  localparam int unsigned NI   = NA + 3;
  localparam logic [NA-1:0] MASK0 = 7'b0000000;
  localparam logic [NA-1:0] MASK1 = 7'b0000100;
  localparam int S_IDLE = 0, S_WAIT = 1, S_QUAL = 2, S_RUN = 3, S_FAULT = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks;
  int   n_fail;

  always #5 clk = ~clk;

  rpsc_interlock_card_if #(.N_ALARM(NA)) if0 ();
  rpsc_interlock_card_if #(.N_ALARM(NA)) if1 ();

  assign if1.alarm_in  = if0.alarm_in;
  assign if1.an_ps_in  = if0.an_ps_in;
  assign if1.ps_act_in = if0.ps_act_in;
  assign if1.u_low_in  = if0.u_low_in;
  assign if1.ack_clr   = if0.ack_clr;

  rpsc_interlock_card #(
    .N_ALARM(NA), .ALARM_MASK(MASK0), .DEB_CYCLES(DEB), .QUAL_CYCLES(QUAL), .LATCH_ALARMS(1'b1)
  ) dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );

  rpsc_interlock_card #(
    .N_ALARM(NA), .ALARM_MASK(MASK1), .DEB_CYCLES(DEB), .QUAL_CYCLES(QUAL), .LATCH_ALARMS(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  // Behavioural model state
  logic [NI-1:0] m_p1, m_p2, m_filt;
  logic [NI-1:0] m_win[$];
  int            m_st[2];
  logic [NA-1:0] m_lat[2];
  int            m_ff[2];
  int            m_qstart[2];
  int            m_fc[2];
  int            cyc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest_plus1(input logic [NA-1:0] v);
    for (int i = 0; i < int'(NA); i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_filt = '0;
    m_win.delete();
    for (int d = 0; d < 2; d++) begin
      m_st[d] = S_FAULT; m_lat[d] = '0; m_ff[d] = 0; m_qstart[d] = 0; m_fc[d] = 0;
    end
  endtask

  // One clock edge of the model, evaluated from pre-edge state and current inputs.
  task automatic model_edge();
    logic [NI-1:0] raw, nfilt;
    logic [NA-1:0] act, mask;
    bit            all_diff, an, ps;
    int            ns;
    cyc++;
    raw = {if0.u_low_in, if0.ps_act_in, if0.an_ps_in, if0.alarm_in};
    m_win.push_back(m_p2);
    if (m_win.size() > DEB) void'(m_win.pop_front());
    nfilt = m_filt;
    if (m_win.size() == DEB) begin
      for (int b = 0; b < int'(NI); b++) begin
        all_diff = 1'b1;
        foreach (m_win[k]) if (m_win[k][b] == m_filt[b]) all_diff = 1'b0;
        if (all_diff) nfilt[b] = ~m_filt[b];
      end
    end
    an = m_filt[NA];
    ps = m_filt[NA+1];
    for (int d = 0; d < 2; d++) begin
      mask = (d == 0) ? MASK0 : MASK1;
      act  = m_filt[NA-1:0] & ~mask;
      ns   = m_st[d];
      if (m_st[d] != S_FAULT && m_lat[d] != '0) ns = S_FAULT;
      else begin
        case (m_st[d])
          S_IDLE: if (!an) ns = S_WAIT;
          S_WAIT: begin
            if (an) ns = S_IDLE;
            else if (ps) begin ns = S_QUAL; m_qstart[d] = cyc; end
          end
          S_QUAL: begin
            if (an) ns = S_IDLE;
            else if (!ps) ns = S_WAIT;
            else if (cyc - m_qstart[d] == int'(QUAL)) ns = S_RUN;
          end
          S_RUN: begin
            if (an) ns = S_IDLE;
            else if (!ps) ns = S_WAIT;
          end
          default: if (m_lat[d] == '0) ns = S_IDLE;
        endcase
      end
      if (m_st[d] != S_FAULT && ns == S_FAULT) begin
        m_ff[d] = lowest_plus1(m_lat[d]);
        if (m_fc[d] < 255) m_fc[d]++;
      end else if (if0.ack_clr && m_st[d] != S_FAULT) begin
        m_ff[d] = 0;
      end
      m_lat[d] = if0.ack_clr ? act : (m_lat[d] | act);
      m_st[d]  = ns;
    end
    m_filt = nfilt;
    m_p2   = m_p1;
    m_p1   = raw;
  endtask

  task automatic check_one(input int d, input logic [2:0] st, input logic na, input logic gho,
                           input logic nop, input logic nps, input logic npok, input logic nul,
                           input logic [2:0] ff, input logic [7:0] fc);
    int   es;
    logic egho;
    int   efc;
    es   = m_st[d];
    egho = (es == S_WAIT) || (es == S_QUAL) || (es == S_RUN);
`ifdef RPSC_FAULT_COUNT_EN
    efc = m_fc[d];
`else
    efc = 0;
`endif
    check_eq($sformatf("d%0d.state", d), 32'(st), 32'(es));
    check_eq($sformatf("d%0d.not_alarm", d), 32'(na), 32'(es != S_FAULT));
    check_eq($sformatf("d%0d.ground_hold_ok", d), 32'(gho), 32'(egho));
    check_eq($sformatf("d%0d.not_on_perm", d), 32'(nop), 32'(!egho));
    check_eq($sformatf("d%0d.not_ps_on", d), 32'(nps), 32'(!m_filt[NA+1]));
    check_eq($sformatf("d%0d.not_ps_ok", d), 32'(npok), 32'(es != S_RUN));
    check_eq($sformatf("d%0d.not_u_low", d), 32'(nul), 32'(!(es == S_RUN && m_filt[NA+2])));
    check_eq($sformatf("d%0d.first_fault", d), 32'(ff), 32'(m_ff[d]));
    check_eq($sformatf("d%0d.fault_count", d), 32'(fc), 32'(efc));
  endtask

  task automatic check_all();
    check_one(0, if0.state, if0.not_alarm, if0.ground_hold_ok, if0.not_on_perm, if0.not_ps_on,
              if0.not_ps_ok, if0.not_u_low, if0.first_fault, if0.fault_count);
    check_one(1, if1.state, if1.not_alarm, if1.ground_hold_ok, if1.not_on_perm, if1.not_ps_on,
              if1.not_ps_ok, if1.not_u_low, if1.first_fault, if1.fault_count);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_state(input int target, input int budget, input string tag, output int n);
    n = 0;
    while (int'(if0.state) != target && n < budget) begin
      step();
      n++;
    end
    check_eq({tag, "_reached"}, 32'(if0.state), 32'(target));
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    if0.alarm_in = '0; if0.an_ps_in = 1'b0; if0.ps_act_in = 1'b0;
    if0.u_low_in = 1'b0; if0.ack_clr = 1'b0;
    reset = 1'b0;
    model_reset();

    // 1. Reset values, then FAULT -> IDLE -> WAIT_ACT
    repeat (3) step();
    check_eq("rst_state", 32'(if0.state), 32'(S_FAULT));
    check_eq("rst_not_on_perm", 32'(if0.not_on_perm), 32'd1);
    reset = 1'b1;
    step();
    check_eq("t1_idle", 32'(if0.state), 32'(S_IDLE));
    step();
    check_eq("t1_wait", 32'(if0.state), 32'(S_WAIT));
    check_eq("t1_ghok", 32'(if0.ground_hold_ok), 32'd1);
    check_eq("t1_not_alarm", 32'(if0.not_alarm), 32'd1);

    // 2. PS qualification and U-low
    if0.ps_act_in = 1'b1;
    repeat (6) step();
    check_eq("t2_not_ps_on", 32'(if0.not_ps_on), 32'd0);
    wait_state(S_QUAL, 10, "t2_qual", n);
    wait_state(S_RUN, 200, "t2_run", n);
    check_eq("t2_qual_len", 32'(n), 32'(QUAL));
    check_eq("t2_not_ps_ok", 32'(if0.not_ps_ok), 32'd0);
    if0.u_low_in = 1'b1;
    repeat (6) step();
    check_eq("t2_not_u_low", 32'(if0.not_u_low), 32'd0);

    // 3. Short ps_act pulse is filtered out
    if0.ps_act_in = 1'b0;
    wait_state(S_WAIT, 20, "t3_wait", n);
    if0.ps_act_in = 1'b1;
    repeat (3) step();
    if0.ps_act_in = 1'b0;
    repeat (10) step();
    check_eq("t3_still_wait", 32'(if0.state), 32'(S_WAIT));
    check_eq("t3_not_ps_on", 32'(if0.not_ps_on), 32'd1);

    // 4. Interrupted qualification restarts from zero
    if0.ps_act_in = 1'b1;
    wait_state(S_QUAL, 20, "t4_qual", n);
    repeat (50) step();
    if0.ps_act_in = 1'b0;
    wait_state(S_WAIT, 20, "t4_wait", n);
    if0.ps_act_in = 1'b1;
    wait_state(S_QUAL, 20, "t4_requal", n);
    wait_state(S_RUN, 200, "t4_run", n);
    check_eq("t4_qual_len", 32'(n), 32'(QUAL));

    // 5. Simultaneous alarms in RUN, lowest index wins; masked card reports channel 5
    if0.alarm_in = 7'b0100100;
    wait_state(S_FAULT, 20, "t5_fault", n);
    check_eq("t5_ff0", 32'(if0.first_fault), 32'd3);
    check_eq("t5_ff1", 32'(if1.first_fault), 32'd6);
    check_eq("t5_not_alarm", 32'(if0.not_alarm), 32'd0);
    check_eq("t5_not_ps_ok", 32'(if0.not_ps_ok), 32'd1);
    if0.alarm_in = '0;
    repeat (10) step();
    check_eq("t5_held", 32'(if0.state), 32'(S_FAULT));
    if0.ack_clr = 1'b1;
    step();
    if0.ack_clr = 1'b0;
    step();
    check_eq("t5_idle", 32'(if0.state), 32'(S_IDLE));
    check_eq("t5_ff_kept", 32'(if0.first_fault), 32'd3);

    // 6. Asynchronous reset mid-QUALIFY
    wait_state(S_QUAL, 20, "t6_qual", n);
    repeat (30) step();
    #3;
    reset = 1'b0;
    #1;
    check_eq("t6_state", 32'(if0.state), 32'(S_FAULT));
    check_eq("t6_not_alarm", 32'(if0.not_alarm), 32'd0);
    check_eq("t6_ghok", 32'(if0.ground_hold_ok), 32'd0);
    check_eq("t6_not_ps_on", 32'(if0.not_ps_on), 32'd1);
    check_eq("t6_not_ps_ok", 32'(if0.not_ps_ok), 32'd1);
    check_eq("t6_not_u_low", 32'(if0.not_u_low), 32'd1);
    model_reset();
    check_all();
    step();
    reset = 1'b1;
    wait_state(S_QUAL, 30, "t6_requal", n);
    wait_state(S_RUN, 200, "t6_run", n);
    check_eq("t6_qual_len", 32'(n), 32'(QUAL));

    // 7. Randomised operation against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(49) == 0) if0.an_ps_in = ~if0.an_ps_in;
      if ($urandom_range(39) == 0) if0.ps_act_in = ~if0.ps_act_in;
      if ($urandom_range(29) == 0) if0.u_low_in = ~if0.u_low_in;
      for (int b = 0; b < int'(NA); b++) begin
        if ($urandom_range(399) == 0) if0.alarm_in[b] = ~if0.alarm_in[b];
      end
      if0.ack_clr = ($urandom_range(19) == 0);
      step();
    end

    // 8. Repeated fault entries exercise fault_count saturation
    if0.alarm_in = '0; if0.an_ps_in = 1'b0; if0.ack_clr = 1'b0;
    repeat (10) step();
    if0.ack_clr = 1'b1;
    step();
    if0.ack_clr = 1'b0;
    repeat (3) step();
    for (int k = 0; k < 300; k++) begin
      if0.alarm_in = 7'b0000001;
      repeat (8) step();
      if0.alarm_in = '0;
      repeat (8) step();
      if0.ack_clr = 1'b1;
      step();
      if0.ack_clr = 1'b0;
      repeat (2) step();
    end
`ifdef RPSC_FAULT_COUNT_EN
    check_eq("t8_fault_count", 32'(if0.fault_count), 32'd255);
`else
    check_eq("t8_fault_count", 32'(if0.fault_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
